prio_enc_queue: RTL and testbench
=================================

// Module: prio_enc_queue
// PURPOSE
//  Parametrised, registered successor to the fixed 4:2 encoder: N_IN-to-log2(N_IN) priority encoder.
//  Request bits are latched into a pending bitmap. One encoded index is delivered per valid/ready
//  handshake, so simultaneous or back-to-back requests are all served in priority order.
//  Sits between event/interrupt sources and a single-index consumer (e.g. a dispatcher).
// PARAMETERS
//  N_IN   8               number of request lines, >=2, power of two not required
//  OUT_W  $clog2(N_IN)    localparam; index width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  req_i        in   N_IN   request bits, sampled every clk; bit k = event k
//  out_ready_i  in   1      consumer accepts out_idx_o this cycle
//  out_valid_o  out  1      out_idx_o holds an undelivered index
//  out_idx_o    out  OUT_W  encoded index of the granted request
//  pend_o       out  N_IN   pending bitmap P (registered)
//  lost_o       out  1      1-cycle registered pulse: request merged into an already-pending bit
// BEHAVIOUR
//  Reset (async, rst_n=0): P=0, out_valid_o=0, out_idx_o=0, lost_o=0, RR pointer=0; takes effect
//    immediately, including mid-transfer; no index is re-emitted after release.
//  Output stage FSM: EMPTY (out_valid_o=0) / FULL (out_valid_o=1).
//    load = (EMPTY | out_ready_i) & |P. On load: out_idx_o <= pick(P), FULL; grant one-hot G = bit picked.
//    FULL & out_ready_i & P==0 -> EMPTY.  FULL & !out_ready_i -> hold out_idx_o stable, G=0.
//  Pending update: P <= (P & ~G) | req_i. Same-cycle clear and re-request of bit k: bit stays set, not lost.
//  lost_o <= |(req_i & P & ~G). The duplicate request is merged; only one index is delivered.
//  Latency: req_i at edge t -> P at t+1 -> out_valid_o/out_idx_o at t+2. Throughput 1 index/cycle.
//  pick uses registered P only. Requests arriving this cycle are not visible until next cycle.
//  Fixed priority (default): highest set index wins (bit N_IN-1 dominates, as in the 4:2 encoder).
//  out_idx_o width OUT_W. For non-power-of-two N_IN, indices >= N_IN never appear.
// CONFIGURATION
//  `PRIO_ENC_ROUND_ROBIN_EN defined: rotating priority. The search starts at ptr and walks upward,
//    wrapping N_IN-1 -> 0. First set bit wins. After each load of index k: ptr <= (k==N_IN-1) ? 0 : k+1.
//    ptr resets to 0. No bit can starve.
//  Undefined: fixed highest-index priority, no ptr register. Low bits may starve under continuous load.
// STRUCTURE
//  Package prio_enc_pkg: typedef enum logic {ST_EMPTY, ST_FULL} out_st_e.
//  Sub-module prio_enc_pick (combinational): inputs P and ptr, outputs idx and one-hot G.
//    Contains both the fixed and the rotating search, selected by the macro. Top holds P, FSM, ptr, lost_o.
// TESTING (N_IN=8)
//  1 Reset: rst_n=0 -> out_valid_o=0, out_idx_o=0, pend_o=0, lost_o=0. Release, then req_i=8'h01
//    for 1 cycle -> out_valid_o=1, out_idx_o=0 two edges later.
//  2 Priority: req_i=8'b1001_0100 for 1 cycle, ready=1 -> idx 7,4,2 on consecutive cycles,
//    then out_valid_o=0, pend_o=0.
//  3 Backpressure: ready=0, req bit 3 -> out_idx_o=3 held stable for 5 cycles.
//    ready=1 -> accepted once, then out_valid_o=0.
//  4 Lost: ready=0, output holds 3, bit 5 pending. Pulse req bit 5 again -> lost_o=1 for exactly
//    1 cycle. Index 5 is delivered once.
//  5 Async reset mid-stream: P=8'hFF, FULL. Drop rst_n between edges -> outputs clear without a clk
//    edge. After release, no index appears until a new request.
//  6 req_i=8'b1000_0001 held, ready=1: with macro -> idx 0,7,0,7...; without macro -> idx 7 every cycle.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types for the registered priority-encoder queue.
// Optional rotating priority is enabled with `PRIO_ENC_ROUND_ROBIN_EN.
package prio_enc_pkg;
   typedef enum logic {ST_EMPTY, ST_FULL} out_st_e;
endpackage

// File: rtl/prio_enc_pick.sv
// Combinational pick over the pending bitmap: returns index and one-hot of the winner.
// `PRIO_ENC_ROUND_ROBIN_EN selects the rotating search starting at i_ptr; otherwise highest index wins.
module prio_enc_pick #(
   parameter  int N_IN  = 8,
   localparam int OUT_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  i_pend,
   input  logic [OUT_W-1:0] i_ptr,
   output logic [OUT_W-1:0] o_idx,
   output logic [N_IN-1:0]  o_oh
);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
   // Walk offsets from farthest to nearest so the first set bit at or above ptr is left standing.
   always_comb begin
      int k;
      k     = 0;
      o_idx = '0;
      o_oh  = '0;
      for (int d = N_IN - 1; d >= 0; d--) begin
         k = int'(i_ptr) + d;
         if (k >= N_IN) k = k - N_IN;
         if (i_pend[k]) begin
            o_idx = OUT_W'(k);
            o_oh  = N_IN'(1) << k;
         end
      end
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      o_idx = '0;
      o_oh  = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (i_pend[k]) begin
            o_idx = OUT_W'(k);
            o_oh  = N_IN'(1) << k;
         end
      end
   end
`endif
endmodule

// File: rtl/prio_enc_queue.sv
// Registered N_IN-to-log2 priority encoder with a pending bitmap and a valid/ready output stage.
// `PRIO_ENC_ROUND_ROBIN_EN adds a rotating-priority pointer; default is fixed highest-index priority.
module prio_enc_queue
   import prio_enc_pkg::*;
#(
   parameter  int N_IN  = 8,
   localparam int OUT_W = $clog2(N_IN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  req_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [OUT_W-1:0] out_idx_o,
   output logic [N_IN-1:0]  pend_o,
   output logic             lost_o
);
   out_st_e          r_state;
   logic [N_IN-1:0]  r_pend;
   logic [OUT_W-1:0] r_idx;
   logic             r_lost;
   logic             w_load;
   logic [OUT_W-1:0] w_pick_idx;
   logic [OUT_W-1:0] w_ptr;
   logic [N_IN-1:0]  w_pick_oh;
   logic [N_IN-1:0]  w_grant;

   assign w_load  = ((r_state == ST_EMPTY) || out_ready_i) && (|r_pend);
   assign w_grant = w_load ? w_pick_oh : '0;

   prio_enc_pick #(.N_IN(N_IN)) u_pick (
      .i_pend (r_pend),
      .i_ptr  (w_ptr),
      .o_idx  (w_pick_idx),
      .o_oh   (w_pick_oh)
   );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   logic [OUT_W-1:0] r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (w_load)
         r_ptr <= (w_pick_idx == OUT_W'(N_IN - 1)) ? '0 : w_pick_idx + 1'b1;
   end
   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   // A bit cleared by this grant and re-requested in the same cycle stays pending and is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_lost <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_grant) | req_i;
         r_lost <= |(req_i & r_pend & ~w_grant);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_load) begin
                  r_idx   <= w_pick_idx;
                  r_state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_load)
                  r_idx <= w_pick_idx;
               else if (out_ready_i)
                  r_state <= ST_EMPTY;
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   assign out_valid_o = (r_state == ST_FULL);
   assign out_idx_o   = r_idx;
   assign pend_o      = r_pend;
   assign lost_o      = r_lost;
endmodule

// File: tb/tb_prio_enc_queue.sv
// Directed bench for prio_enc_queue (N_IN=8); expectations follow `PRIO_ENC_ROUND_ROBIN_EN when defined.
module tb_prio_enc_queue;
   localparam int N_IN = 8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_i;
   logic       out_ready_i;
   logic       out_valid_o;
   logic [2:0] out_idx_o;
   logic [7:0] pend_o;
   logic       lost_o;

   int n_cmp;
   int n_err;

   prio_enc_queue #(.N_IN(N_IN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .out_ready_i (out_ready_i),
      .out_valid_o (out_valid_o),
      .out_idx_o   (out_idx_o),
      .pend_o      (pend_o),
      .lost_o      (lost_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp2 [3];
      logic [2:0] exp6 [6];
      n_cmp = 0;
      n_err = 0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      exp2 = '{3'd2, 3'd4, 3'd7};
      exp6 = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7};
`else
      exp2 = '{3'd7, 3'd4, 3'd2};
      exp6 = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif

      // 1: reset state and first-request latency
      rst_n = 1'b0; req_i = '0; out_ready_i = 1'b0;
      #3;
      chk("rst_valid", 32'(out_valid_o), 0);
      chk("rst_idx",   32'(out_idx_o),   0);
      chk("rst_pend",  32'(pend_o),      0);
      chk("rst_lost",  32'(lost_o),      0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      req_i = 8'h01;
      tick();
      req_i = 8'h00;
      chk("t1_pend", 32'(pend_o), 32'h01);
      chk("t1_valid_early", 32'(out_valid_o), 0);
      tick();
      chk("t1_valid", 32'(out_valid_o), 1);
      chk("t1_idx",   32'(out_idx_o),   0);
      out_ready_i = 1'b1;
      tick();
      chk("t1_drain", 32'(out_valid_o), 0);

      // 2: three simultaneous requests served one per cycle
      req_i = 8'b1001_0100;
      tick();
      req_i = 8'h00;
      chk("t2_pend", 32'(pend_o), 32'h94);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t2_valid%0d", i), 32'(out_valid_o), 1);
         chk($sformatf("t2_idx%0d", i),   32'(out_idx_o),   32'(exp2[i]));
      end
      tick();
      chk("t2_empty", 32'(out_valid_o), 0);
      chk("t2_pend0", 32'(pend_o),      0);

      // 3: backpressure holds the index
      out_ready_i = 1'b0;
      req_i = 8'h08;
      tick();
      req_i = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t3_hold_v%0d", i), 32'(out_valid_o), 1);
         chk($sformatf("t3_hold_i%0d", i), 32'(out_idx_o),   3);
      end
      out_ready_i = 1'b1;
      tick();
      chk("t3_acc", 32'(out_valid_o), 0);
      tick();
      chk("t3_once", 32'(out_valid_o), 0);

      // 4: duplicate request on a pending bit
      out_ready_i = 1'b0;
      req_i = 8'h08;
      tick();
      req_i = 8'h20;
      tick();
      chk("t4_idx3",  32'(out_idx_o), 3);
      chk("t4_pend",  32'(pend_o),    32'h20);
      chk("t4_nolost", 32'(lost_o),   0);
      tick();
      req_i = 8'h00;
      chk("t4_lost",  32'(lost_o),    1);
      chk("t4_hold",  32'(out_idx_o), 3);
      tick();
      chk("t4_lost1cyc", 32'(lost_o), 0);
      out_ready_i = 1'b1;
      tick();
      chk("t4_v5",   32'(out_valid_o), 1);
      chk("t4_idx5", 32'(out_idx_o),   5);
      tick();
      chk("t4_once", 32'(out_valid_o), 0);

      // 5: asynchronous reset between edges
      out_ready_i = 1'b0;
      req_i = 8'hFF;
      tick(); tick();
      req_i = 8'h00;
      chk("t5_pendFF", 32'(pend_o),      32'hFF);
      chk("t5_full",   32'(out_valid_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_arst_v", 32'(out_valid_o), 0);
      chk("t5_arst_i", 32'(out_idx_o),   0);
      chk("t5_arst_p", 32'(pend_o),      0);
      chk("t5_arst_l", 32'(lost_o),      0);
      #2;
      rst_n = 1'b1;
      out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_quiet%0d", i), 32'(out_valid_o), 0);
      end

      // 6: two requests held continuously
      req_i = 8'b1000_0001;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t6_v%0d", i),   32'(out_valid_o), 1);
         chk($sformatf("t6_idx%0d", i), 32'(out_idx_o),   32'(exp6[i]));
      end
      req_i = 8'h00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
